// File: rtl/in_module_control.sv
// in_module_control: stalls the CPU on an IN instruction until the user presses enter, then delivers the switch value.
// Latency: the press is seen 2 sync + DEBOUNCE_CYCLES cycles after the raw edge; binary/data_valid update one cycle later.
// Backpressure: stall holds the CPU while waiting; inputControl must drop between requests (DONE blocks re-capture).
//
// Ports:
//   clk          system clock, rising-edge
//   rst          asynchronous active-high reset
//   inputControl CPU request, high while an IN instruction is in execute
//   switches     raw board switches (asynchronous)
//   enter_btn    raw active-high pushbutton (bouncing, asynchronous)
//   binary       extended captured switch value, held until the next capture
//   data_valid   one-cycle pulse when binary is updated
//   stall        freezes the CPU PC/pipeline while high
//   in_wait      "awaiting input" indicator
module in_module_control #(
  parameter int SW_WIDTH        = 16,
  parameter int SIGN_EXT        = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inputControl,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                enter_btn,
  output logic [31:0]         binary,
  output logic                data_valid,
  output logic                stall,
  output logic                in_wait
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_RELEASE,
    ST_WAIT_PRESS,
    ST_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-stage synchronizers for the asynchronous board inputs.
  // The switches are expected to be static while the button is pressed, so a
  // per-bit synchronizer is sufficient (no bus-coherency handshake needed).
  // ---------------------------------------------------------------------------
  logic                r_btn_s1;
  logic                r_btn_s2;
  logic [SW_WIDTH-1:0] r_sw_s1;
  logic [SW_WIDTH-1:0] r_sw_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= enter_btn;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= switches;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: the accepted level only flips after the synchronized button has
  // disagreed with it for DEBOUNCE_CYCLES consecutive cycles. Any agreement
  // in between restarts the count, so bounces shorter than that are dropped.
  // r_press_evt is registered alongside the flip, so it is high exactly in the
  // first cycle the debounced level reads 1.
  // ---------------------------------------------------------------------------
  logic             r_btn_db;
  logic [CNT_W-1:0] r_db_cnt;
  logic             r_press_evt;
  logic             w_db_flip;

  assign w_db_flip = (r_btn_s2 != r_btn_db) && (r_db_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_db    <= 1'b0;
      r_db_cnt    <= '0;
      r_press_evt <= 1'b0;
    end else begin
      r_press_evt <= w_db_flip && !r_btn_db;
      if (r_btn_s2 == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (w_db_flip) begin
        r_btn_db <= r_btn_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Width extension of the synchronized switches to a 32-bit word.
  // ---------------------------------------------------------------------------
  logic [31:0] w_sw_ext;

  generate
    if (SW_WIDTH >= 32) begin : g_no_ext
      assign w_sw_ext = r_sw_s2[31:0];
    end else begin : g_ext
      logic w_fill;
      assign w_fill   = (SIGN_EXT != 0) ? r_sw_s2[SW_WIDTH-1] : 1'b0;
      assign w_sw_ext = {{(32 - SW_WIDTH){w_fill}}, r_sw_s2};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;
  logic   w_capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    stall       = 1'b0;
    in_wait     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Stall in the very cycle the request appears so the CPU never
        // advances past the IN instruction.
        if (inputControl) begin
          stall       = 1'b1;
          w_state_nxt = ST_WAIT_RELEASE;
        end
      end

      ST_WAIT_RELEASE: begin
        // A button already held when the request arrived must be released
        // first; only a fresh press is accepted.
        stall   = 1'b1;
        in_wait = 1'b1;
        if (!inputControl) begin
          w_state_nxt = ST_IDLE;
        end else if (!r_btn_db) begin
          w_state_nxt = ST_WAIT_PRESS;
        end
      end

      ST_WAIT_PRESS: begin
        stall   = 1'b1;
        in_wait = 1'b1;
        // A dropped request wins over a simultaneous press: abort silently.
        if (!inputControl) begin
          w_state_nxt = ST_IDLE;
        end else if (r_press_evt) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        // Park here until the CPU leaves the IN instruction so the same
        // instruction is never captured twice.
        if (!inputControl) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // The IDLE-cycle stall is combinational from inputControl; keep it low
    // while reset is held so all outputs sit at their reset values.
    if (rst) begin
      stall = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Captured value and its valid pulse
  // ---------------------------------------------------------------------------
  logic [31:0] r_binary;
  logic        r_data_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_binary     <= 32'h0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_capture;
      if (w_capture) begin
        r_binary <= w_sw_ext;
      end
    end
  end

  assign binary     = r_binary;
  assign data_valid = r_data_valid;

endmodule

// File: doc/in_module_control.md
Name: in_module_control

Overview:
Input-side counterpart of the CPU's output display control. When the CPU executes an IN instruction, this block stalls the processor and lights an "awaiting input" indicator. It waits for the user to set the switches and press a debounced enter button, then delivers the switch value as a 32-bit word and releases the stall. It sits between the board switches/pushbutton and the CPU datapath's register write-back mux.

Parameters:
SW_WIDTH, 16, number of data switches sampled.
SIGN_EXT, 1, 1 = sign-extend switches to 32 bits; 0 = zero-extend.
DEBOUNCE_CYCLES, 50000, consecutive stable clock cycles required to accept a button level change (minimum 2).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
inputControl  input  1  CPU request; high while an IN instruction is in execute.
switches  input  SW_WIDTH  raw board switches, asynchronous to clk.
enter_btn  input  1  raw pushbutton, active-high, bouncing, asynchronous.
binary  output  32  extended captured value; held until the next capture.
data_valid  output  1  one-cycle pulse when binary is updated.
stall  output  1  freezes the CPU PC and pipeline while high.
in_wait  output  1  indicator LED; high while waiting for the user.

Behaviour:
- Reset (async, rst=1): state=IDLE; binary=0, data_valid=0, stall=0, in_wait=0; debounce counter=0; debounced button=0; synchronizers cleared.
- Synchronizers: enter_btn and switches each pass through two flip-flop stages before use.
- Debounce:
  - Counter increments while the synchronized button differs from the debounced level; it clears when the two match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - press_evt is a one-cycle pulse on a debounced 0->1 transition.
  - Latency from a clean raw edge to press_evt is 2 + DEBOUNCE_CYCLES cycles (±1).
- FSM:
  - IDLE: stall=0, in_wait=0. If inputControl=1 -> WAIT_RELEASE, with stall=1 asserted combinationally in the same cycle inputControl rises.
  - WAIT_RELEASE: stall=1, in_wait=1. Moves to WAIT_PRESS once the debounced button=0, so a button already held when the request arrives is not accepted.
  - WAIT_PRESS: stall=1, in_wait=1. On press_evt: binary <= extended synchronized switches, data_valid <= 1, next state DONE.
  - DONE: stall=0, in_wait=0, data_valid=0. Stays in DONE while inputControl=1, so the same instruction is not re-captured. Returns to IDLE when inputControl=0.
- Extension: bits [SW_WIDTH-1:0] take the switches. Upper bits are switches[SW_WIDTH-1] if SIGN_EXT=1, otherwise 0. If SW_WIDTH=32, no extension is applied.
- stall is high exactly in WAIT_RELEASE and WAIT_PRESS, plus the IDLE cycle where inputControl=1. The CPU samples binary in the first cycle stall=0 after data_valid.
- If inputControl drops while in WAIT_*: abort to IDLE, binary is unchanged, and no data_valid pulse is issued.
- press_evt in IDLE or DONE is ignored.
- Switch changes after capture do not affect binary.
- Back-to-back IN instructions require inputControl to go low for at least one cycle between them.
- rst asserted mid-wait: all outputs drop to their reset values immediately. After rst deasserts, an inputControl that is still high starts a new request.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4.)
1. Reset: rst=1 with enter_btn=1 and switches=16'hFFFF -> binary=0, stall=0, in_wait=0, data_valid=0 throughout reset.
2. Normal capture:
   - Stimulus: SIGN_EXT=1, switches=16'h8001, inputControl=1, then a clean press held 10 cycles.
   - Required: stall=1 from the request cycle; data_valid pulses once; binary=32'hFFFF8001; stall=0 the cycle after the pulse.
   - Repeat with SIGN_EXT=0 -> binary=32'h00008001.
3. Bounce rejection: toggle enter_btn every 2 cycles for 12 cycles, then hold high -> exactly one data_valid pulse, occurring only after the stable period.
4. Pre-held button: enter_btn held high before inputControl rises -> no capture. After release and a new press, binary=switches.
5. Abort: inputControl drops while in WAIT_PRESS -> stall=0 next cycle; binary keeps its previous value (e.g. 32'h00000005); no data_valid.
6. Async reset mid-wait: assert rst between clock edges while stall=1 -> stall=0 and in_wait=0 before the next clock edge. A new request after reset captures normally.
